// File: rtl/oled_status_streamer.sv
// Streams one of seven fixed game-status text lines to the OLED controller.
// The stream restarts whenever the decoded status changes or a refresh is requested.
module oled_status_streamer #(
  parameter int          LINE_LEN = 16,
  parameter logic [7:0]  PAD_CHAR = 8'h20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic [1:0] winner,
  input  logic       draw,
  input  logic       refresh,
  output logic [7:0] send_data,
  output logic       send_valid,
  input  logic       send_done,
  output logic       busy,
  output logic       msg_done,
  output logic [2:0] msg_idx
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_msg_done;
  logic [2:0]    r_msg_idx;
  logic          r_first;
  logic          r_refresh;

  logic [2:0]    w_sel;
  logic          w_pending;
  logic          w_start;
  logic          w_last;

  // Leftmost character sits in the top byte of each line.
  function automatic logic [7:0] rom_byte(
    input logic [2:0]    idx,
    input logic [CW-1:0] pos
  );
    logic [127:0] l_line;
    logic [5:0]   l_pos;
    case (idx)
      3'd1:    l_line = "PLAYER1         ";
      3'd2:    l_line = "PLAYER2         ";
      3'd3:    l_line = "GAME_OVER       ";
      3'd4:    l_line = "WINNER PLAYER1  ";
      3'd5:    l_line = "WINNER PLAYER2  ";
      3'd6:    l_line = "DRAW            ";
      default: l_line = "IDLE1           ";
    endcase
    l_pos = 6'(pos);
    if (l_pos[5:4] != 2'd0) return PAD_CHAR;
    return l_line[{4'd15 - l_pos[3:0], 3'b000} +: 8];
  endfunction

  always_comb begin
    w_sel = 3'd0;
    unique case (current_state)
      2'd0: w_sel = 3'd0;
      2'd1: w_sel = 3'd1;
      2'd2: w_sel = 3'd2;
      default: begin
        if (winner == 2'd1)
          w_sel = 3'd4;
        else if (winner == 2'd2)
          w_sel = 3'd5;
        else if (winner == 2'd0 && draw)
          w_sel = 3'd6;
        else
          w_sel = 3'd3;
      end
    endcase
  end

  assign w_pending = r_first | (w_sel != r_msg_idx) | r_refresh;
  assign w_start   = (r_state == S_IDLE) && w_pending;
  assign w_last    = (r_cnt == CW'(LINE_LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_msg_done <= 1'b0;
      r_msg_idx  <= 3'd0;
      r_first    <= 1'b1;
      r_refresh  <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      // A starting stream absorbs a refresh arriving in the same cycle.
      if (w_start)
        r_refresh <= 1'b0;
      else if (refresh)
        r_refresh <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pending) begin
            r_msg_idx <= w_sel;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_first   <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!send_done) begin
            r_data  <= rom_byte(r_msg_idx, r_cnt);
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (send_done) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_busy     <= 1'b0;
              r_msg_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign send_data  = r_data;
  assign send_valid = r_valid;
  assign busy       = r_busy;
  assign msg_done   = r_msg_done;
  assign msg_idx    = r_msg_idx;

endmodule

// File: tb/tb_oled_status_streamer.sv
// Directed bench: three streamers (line lengths 16, 18, 4) share status inputs,
// each with its own 5-cycle-latency controller model.
module tb_oled_status_streamer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cs    = 2'd0;
  logic [1:0] win   = 2'd0;
  logic       drw   = 1'b0;
  logic       rfr   = 1'b0;
  logic       hold0 = 1'b0;

  logic [7:0] sd  [3];
  logic       sv  [3];
  logic       sdn [3];
  logic       bz  [3];
  logic       mdn [3];
  logic [2:0] mi  [3];

  int         lat [3];
  logic [7:0] q   [3][$];
  int         mdc [3];
  bit         pv  [3];
  bit         phs [3];
  logic [7:0] pd  [3];
  int         viol;
  int         total;
  int         bad;

  always #5 clock = ~clock;

  oled_status_streamer #(.LINE_LEN(16)) u16 (
    .clock(clock), .reset(reset), .current_state(cs), .winner(win),
    .draw(drw), .refresh(rfr), .send_data(sd[0]), .send_valid(sv[0]),
    .send_done(sdn[0]), .busy(bz[0]), .msg_done(mdn[0]), .msg_idx(mi[0])
  );

  oled_status_streamer #(.LINE_LEN(18)) u18 (
    .clock(clock), .reset(reset), .current_state(cs), .winner(win),
    .draw(drw), .refresh(rfr), .send_data(sd[1]), .send_valid(sv[1]),
    .send_done(sdn[1]), .busy(bz[1]), .msg_done(mdn[1]), .msg_idx(mi[1])
  );

  oled_status_streamer #(.LINE_LEN(4)) u4 (
    .clock(clock), .reset(reset), .current_state(cs), .winner(win),
    .draw(drw), .refresh(rfr), .send_data(sd[2]), .send_valid(sv[2]),
    .send_done(sdn[2]), .busy(bz[2]), .msg_done(mdn[2]), .msg_idx(mi[2])
  );

  // Controller: raises done after valid has been seen for 5 cycles,
  // drops it once valid falls. hold0 pins the first controller low.
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if ((k == 0 && hold0) || !sv[k]) begin
        sdn[k] <= 1'b0;
        lat[k] <= 0;
      end else if (lat[k] == 5) begin
        sdn[k] <= 1'b1;
      end else begin
        lat[k] <= lat[k] + 1;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (sv[k] && sdn[k]) q[k].push_back(sd[k]);
      if (mdn[k]) mdc[k]++;
      if (pv[k] && sv[k] && (sd[k] !== pd[k] || phs[k])) viol++;
      if (mdn[k] && bz[k]) viol++;
      pv[k]  = sv[k];
      pd[k]  = sd[k];
      phs[k] = sv[k] && sdn[k];
    end
  end

  function automatic logic [7:0] ch(input string s, input int i);
    if (i < s.len()) return s[i];
    return 8'h20;
  endfunction

  task automatic pulse_refresh;
    rfr = 1'b1;
    @(negedge clock);
    rfr = 1'b0;
  endtask

  task automatic wait_quiet;
    int quiet = 0;
    int k = 0;
    while (quiet < 10 && k < 6000) begin
      @(negedge clock);
      k++;
      if (!bz[0] && !bz[1] && !bz[2]) quiet++;
      else quiet = 0;
    end
    total++;
    if (quiet < 10) begin
      bad++;
      $display("FAIL wait_quiet: busy after %0d cycles, want idle", k);
    end
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (q[0].size() < n && k < 3000) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (q[0].size() < n) begin
      bad++;
      $display("FAIL wait_bytes: got %0d want %0d", q[0].size(), n);
    end
  endtask

  task automatic test_reset;
    int b0, b1, b2;
    repeat (3) @(negedge clock);
    total += 5;
    if (sv[0] !== 1'b0) begin bad++; $display("FAIL rst_valid: %b want 0", sv[0]); end
    if (bz[0] !== 1'b0) begin bad++; $display("FAIL rst_busy: %b want 0", bz[0]); end
    if (mdn[0] !== 1'b0) begin bad++; $display("FAIL rst_done: %b want 0", mdn[0]); end
    if (mi[0] !== 3'd0) begin bad++; $display("FAIL rst_idx: %0d want 0", mi[0]); end
    if (sd[0] !== 8'h00) begin bad++; $display("FAIL rst_data: %h want 00", sd[0]); end
    b0 = q[0].size();
    b1 = q[1].size();
    b2 = q[2].size();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bz[0] !== 1'b1 || sv[0] !== 1'b0) begin
      bad++;
      $display("FAIL start1: busy=%b valid=%b want 1 0", bz[0], sv[0]);
    end
    @(negedge clock);
    total++;
    if (sv[0] !== 1'b1 || sd[0] !== 8'h49) begin
      bad++;
      $display("FAIL start2: valid=%b data=%h want 1 49", sv[0], sd[0]);
    end
    wait_quiet();
    total += 3;
    if (q[0].size() - b0 != 16) begin bad++; $display("FAIL idle_cnt: %0d want 16", q[0].size() - b0); end
    if (mdc[0] != 1) begin bad++; $display("FAIL idle_md: %0d want 1", mdc[0]); end
    if (mi[0] !== 3'd0) begin bad++; $display("FAIL idle_idx: %0d want 0", mi[0]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q[0][b0+i] !== ch("IDLE1", i)) begin
        bad++;
        $display("FAIL idle16 byte %0d: %h want %h", i, q[0][b0+i], ch("IDLE1", i));
      end
    end
    for (int i = 0; i < 18; i++) begin
      total++;
      if (q[1][b1+i] !== ch("IDLE1", i)) begin
        bad++;
        $display("FAIL idle18 byte %0d: %h want %h", i, q[1][b1+i], ch("IDLE1", i));
      end
    end
    total++;
    if (q[1].size() - b1 != 18) begin bad++; $display("FAIL idle18_cnt: %0d want 18", q[1].size() - b1); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[2][b2+i] !== ch("IDLE1", i)) begin
        bad++;
        $display("FAIL idle4 byte %0d: %h want %h", i, q[2][b2+i], ch("IDLE1", i));
      end
    end
    total++;
    if (q[2].size() - b2 != 4) begin bad++; $display("FAIL idle4_cnt: %0d want 4", q[2].size() - b2); end
  endtask

  task automatic test_winner;
    int b, m;
    b = q[0].size();
    m = mdc[0];
    cs = 2'd3; win = 2'd1; drw = 1'b1;
    wait_quiet();
    total += 3;
    if (q[0].size() - b != 16) begin bad++; $display("FAIL win_cnt: %0d want 16", q[0].size() - b); end
    if (mdc[0] - m != 1) begin bad++; $display("FAIL win_md: %0d want 1", mdc[0] - m); end
    if (mi[0] !== 3'd4) begin bad++; $display("FAIL win_idx: %0d want 4", mi[0]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q[0][b+i] !== ch("WINNER PLAYER1", i)) begin
        bad++;
        $display("FAIL win byte %0d: %h want %h", i, q[0][b+i], ch("WINNER PLAYER1", i));
      end
    end
    b = q[0].size();
    m = mdc[0];
    win = 2'd0;
    wait_quiet();
    total += 3;
    if (q[0].size() - b != 16) begin bad++; $display("FAIL draw_cnt: %0d want 16", q[0].size() - b); end
    if (mdc[0] - m != 1) begin bad++; $display("FAIL draw_md: %0d want 1", mdc[0] - m); end
    if (mi[0] !== 3'd6) begin bad++; $display("FAIL draw_idx: %0d want 6", mi[0]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q[0][b+i] !== ch("DRAW", i)) begin
        bad++;
        $display("FAIL draw byte %0d: %h want %h", i, q[0][b+i], ch("DRAW", i));
      end
    end
  endtask

  task automatic test_midstream_change;
    int b, m;
    b = q[0].size();
    m = mdc[0];
    cs = 2'd1; win = 2'd0; drw = 1'b0;
    wait_bytes(b + 5);
    cs = 2'd2;
    wait_quiet();
    total += 3;
    if (q[0].size() - b != 32) begin bad++; $display("FAIL mid_cnt: %0d want 32", q[0].size() - b); end
    if (mdc[0] - m != 2) begin bad++; $display("FAIL mid_md: %0d want 2", mdc[0] - m); end
    if (mi[0] !== 3'd2) begin bad++; $display("FAIL mid_idx: %0d want 2", mi[0]); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (q[0][b+i] !== ch(i < 16 ? "PLAYER1" : "PLAYER2", i % 16)) begin
        bad++;
        $display("FAIL mid byte %0d: %h want %h", i, q[0][b+i],
                 ch(i < 16 ? "PLAYER1" : "PLAYER2", i % 16));
      end
    end
  endtask

  task automatic test_refresh;
    int b, m;
    b = q[0].size();
    m = mdc[0];
    pulse_refresh();
    wait_quiet();
    total += 2;
    if (q[0].size() - b != 16) begin bad++; $display("FAIL rf1_cnt: %0d want 16", q[0].size() - b); end
    if (mdc[0] - m != 1) begin bad++; $display("FAIL rf1_md: %0d want 1", mdc[0] - m); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q[0][b+i] !== ch("PLAYER2", i)) begin
        bad++;
        $display("FAIL rf1 byte %0d: %h want %h", i, q[0][b+i], ch("PLAYER2", i));
      end
    end
    b = q[0].size();
    m = mdc[0];
    pulse_refresh();
    wait_bytes(b + 3);
    pulse_refresh();
    wait_bytes(b + 8);
    pulse_refresh();
    wait_quiet();
    total += 2;
    if (q[0].size() - b != 32) begin bad++; $display("FAIL rf2_cnt: %0d want 32", q[0].size() - b); end
    if (mdc[0] - m != 2) begin bad++; $display("FAIL rf2_md: %0d want 2", mdc[0] - m); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (q[0][b+i] !== ch("PLAYER2", i % 16)) begin
        bad++;
        $display("FAIL rf2 byte %0d: %h want %h", i, q[0][b+i], ch("PLAYER2", i % 16));
      end
    end
    b = q[0].size();
    m = mdc[0];
    cs = 2'd1;
    pulse_refresh();
    wait_quiet();
    total += 3;
    if (q[0].size() - b != 16) begin bad++; $display("FAIL rf3_cnt: %0d want 16", q[0].size() - b); end
    if (mdc[0] - m != 1) begin bad++; $display("FAIL rf3_md: %0d want 1", mdc[0] - m); end
    if (q[0][b+6] !== 8'h31) begin bad++; $display("FAIL rf3_byte6: %h want 31", q[0][b+6]); end
  endtask

  task automatic test_line_len;
    int b0, b1, b2, m2;
    b0 = q[0].size();
    b1 = q[1].size();
    b2 = q[2].size();
    m2 = mdc[2];
    cs = 2'd3; win = 2'd0; drw = 1'b0;
    wait_quiet();
    total += 5;
    if (q[0].size() - b0 != 16) begin bad++; $display("FAIL go16_cnt: %0d want 16", q[0].size() - b0); end
    if (q[1].size() - b1 != 18) begin bad++; $display("FAIL go18_cnt: %0d want 18", q[1].size() - b1); end
    if (q[2].size() - b2 != 4) begin bad++; $display("FAIL go4_cnt: %0d want 4", q[2].size() - b2); end
    if (mdc[2] - m2 != 1) begin bad++; $display("FAIL go4_md: %0d want 1", mdc[2] - m2); end
    if (mi[2] !== 3'd3) begin bad++; $display("FAIL go4_idx: %0d want 3", mi[2]); end
    for (int i = 0; i < 18; i++) begin
      total++;
      if (q[1][b1+i] !== ch("GAME_OVER", i)) begin
        bad++;
        $display("FAIL go18 byte %0d: %h want %h", i, q[1][b1+i], ch("GAME_OVER", i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q[2][b2+i] !== ch("GAME", i)) begin
        bad++;
        $display("FAIL go4 byte %0d: %h want %h", i, q[2][b2+i], ch("GAME", i));
      end
    end
  endtask

  task automatic test_reset_midstream;
    int b, m, k;
    b = q[0].size();
    cs = 2'd2;
    wait_bytes(b + 6);
    hold0 = 1'b1;
    k = 0;
    while (!sv[0] && k < 200) begin
      @(negedge clock);
      k++;
    end
    total += 2;
    if (sv[0] !== 1'b1) begin bad++; $display("FAIL rm_valid: %b want 1", sv[0]); end
    if (q[0].size() - b != 6) begin bad++; $display("FAIL rm_pos: %0d want 6", q[0].size() - b); end
    reset = 1'b1;
    @(negedge clock);
    total += 3;
    if (sv[0] !== 1'b0) begin bad++; $display("FAIL rm_rst_valid: %b want 0", sv[0]); end
    if (bz[0] !== 1'b0) begin bad++; $display("FAIL rm_rst_busy: %b want 0", bz[0]); end
    if (mi[0] !== 3'd0) begin bad++; $display("FAIL rm_rst_idx: %0d want 0", mi[0]); end
    reset = 1'b0;
    hold0 = 1'b0;
    b = q[0].size();
    m = mdc[0];
    wait_quiet();
    total += 3;
    if (q[0].size() - b != 16) begin bad++; $display("FAIL rm_cnt: %0d want 16", q[0].size() - b); end
    if (mdc[0] - m != 1) begin bad++; $display("FAIL rm_md: %0d want 1", mdc[0] - m); end
    if (mi[0] !== 3'd2) begin bad++; $display("FAIL rm_idx: %0d want 2", mi[0]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q[0][b+i] !== ch("PLAYER2", i)) begin
        bad++;
        $display("FAIL rm byte %0d: %h want %h", i, q[0][b+i], ch("PLAYER2", i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_winner();
    test_midstream_change();
    test_refresh();
    test_line_len();
    test_reset_midstream();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL protocol: %0d violations want 0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oled_status_streamer.md
# oled_status_streamer

Parametrised game-status text streamer for the Tic-Tac-Toe OLED display. It decodes the game FSM status (`current_state`, `winner`, `draw`) into one of seven fixed 16-character messages. It streams that message byte-by-byte into the OLED controller over its `sendData`/`sendDataValid`/`sendDone` handshake. Unlike the one-shot status printer, it re-streams automatically whenever the decoded message changes or a refresh is requested, pads or truncates to a configurable line length, and reports progress.

## Interface
- `LINE_LEN`, 16, bytes streamed per message (1..64); chars beyond 16 sent as 8'h20, fewer than 16 truncates the message on the right
- `PAD_CHAR`, 8'h20, fill byte used beyond char 16
- `clock`  in  1  system clock (100 MHz)
- `reset`  in  1  synchronous, active-high
- `current_state`  in  2  game FSM state: 0 idle, 1 player1 turn, 2 player2 turn, 3 game over
- `winner`  in  2  0 none, 1 player1, 2 player2, 3 reserved
- `draw`  in  1  draw flag
- `refresh`  in  1  single-cycle request to re-stream the current message
- `send_data`  out  8  ASCII byte to OLED controller
- `send_valid`  out  1  byte valid, held until `send_done`
- `send_done`  in  1  controller byte-accepted / ready-low indication
- `busy`  out  1  high while a message is being streamed
- `msg_done`  out  1  one-cycle pulse after the last byte of a message is accepted
- `msg_idx`  out  3  index of the message being / last streamed

## Operation
- Message ROM (16 chars, leftmost char sent first):
  - 0 "IDLE1           "
  - 1 "PLAYER1         "
  - 2 "PLAYER2         "
  - 3 "GAME_OVER       "
  - 4 "WINNER PLAYER1  "
  - 5 "WINNER PLAYER2  "
  - 6 "DRAW            "
- Decode (`sel`), combinational, priority order:
  - state 0 -> 0; state 1 -> 1; state 2 -> 2
  - state 3 and winner 1 -> 4
  - state 3 and winner 2 -> 5
  - state 3, winner 0, draw 1 -> 6
  - any other state-3 combination -> 3 (winner 3 -> 3; a winner overrides draw)
- `pending` = `first` | (`sel` != `msg_idx`) | `refresh_flag`.
  - `first` is set by reset and cleared when the first message starts.
  - `refresh_flag` is set by `refresh` in any state and cleared when a message starts in IDLE.
- FSM states:
  - IDLE: if `pending`, latch `msg_idx` <= `sel`, `cnt` <= 0, `busy` <= 1, go to LOAD.
  - LOAD: wait for `send_done` == 0. Then register `send_data` = ROM[`msg_idx`][`cnt`] (or `PAD_CHAR` if `cnt` >= 16), set `send_valid` <= 1, go to SEND.
  - SEND: hold `send_data`/`send_valid` stable until `send_done` == 1. Then `send_valid` <= 0.
    - If `cnt` == `LINE_LEN`-1: `busy` <= 0, pulse `msg_done`, go to IDLE.
    - Otherwise `cnt` <= `cnt`+1, go to LOAD.
- A status change mid-stream does not abort the stream. The current message completes, then IDLE re-evaluates and streams the new one.
- `cnt` width is clog2(`LINE_LEN`). The latched `msg_idx` is frozen during a stream; `sel` is sampled only in IDLE.

## Timing
- Reset values: `send_data` 8'h00, `send_valid` 0, `busy` 0, `msg_done` 0, `msg_idx` 0, `first` 1, `refresh_flag` 0, state IDLE.
- Reset wins over every other event and takes effect the cycle after it is sampled, including mid-stream: `send_valid` drops and no further bytes are sent.
- First byte: `send_valid` rises 2 cycles after `pending` is sampled in IDLE, given `send_done` is low.
- Per byte: minimum 3 cycles plus controller latency (LOAD, SEND with done, next LOAD).
- `send_valid` is never high in the same cycle as a state change into LOAD. It is low for at least one cycle between bytes.
- `msg_done` is high exactly in the cycle after the final `send_done`, coincident with the return to IDLE.
- `refresh` and a status change in the same cycle cause one stream of the new message, not two.

## Test plan
- Reset with state=0, `send_done` modelled as a 5-cycle-latency responder -> 16 bytes "IDLE1" plus 11 x 8'h20 in order, one `msg_done` pulse, `busy` low after, `msg_idx`=0.
- Idle settled, set state=3, winner=1, draw=1 -> "WINNER PLAYER1  " streamed, `msg_idx`=4 (winner overrides draw). Then winner=0, draw=1 -> "DRAW" plus spaces streamed, `msg_idx`=6.
- Change state 1->2 after byte 5 of "PLAYER1" -> all 16 bytes of PLAYER1 complete, then PLAYER2 streamed; exactly 32 handshakes total.
- `refresh` pulse with no status change -> identical 16-byte message re-streamed. Two `refresh` pulses during a stream -> exactly one extra stream.
- `LINE_LEN`=18 -> bytes 17 and 18 are 8'h20. `LINE_LEN`=4, state=3, winner=0, draw=0 -> "GAME" only, then `msg_done`.
- Assert `reset` while in SEND on byte 7 with `send_done` held low -> next cycle `send_valid`=0, `busy`=0, `msg_idx`=0. After release, the full message restarts from byte 0.
